// File: rtl/decode_issue.sv
// rtl/decode_issue.sv - in-order fetch/decode/operand-read sequencer feeding ALU control
module decode_issue #(
  parameter int WORD_SIZE = 16,
  parameter int OP_SIZE   = 4,
  parameter int PC_SIZE   = 8
) (
  input  logic                 tclk,
  input  logic                 rst,
  output logic                 imem_req,
  output logic [PC_SIZE-1:0]   imem_addr,
  input  logic                 imem_ack,
  input  logic [WORD_SIZE-1:0] imem_data,
  output logic [OP_SIZE-1:0]   rf_raddr_a,
  output logic [OP_SIZE-1:0]   rf_raddr_b,
  input  logic [WORD_SIZE-1:0] rf_rdata_a,
  input  logic [WORD_SIZE-1:0] rf_rdata_b,
  output logic [OP_SIZE-1:0]   sel,
  output logic [WORD_SIZE-1:0] data1_out,
  output logic [WORD_SIZE-1:0] data2_out,
  output logic [WORD_SIZE-1:0] data3_out,
  output logic                 issue_valid,
  input  logic                 issue_ready,
  output logic                 halted
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_READ   = 3'd2;
  localparam logic [2:0] S_ISSUE  = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  localparam logic [OP_SIZE-1:0] OP_NOP  = '0;
  localparam logic [OP_SIZE-1:0] OP_HALT = '1;
  localparam logic [OP_SIZE-1:0] OP_LI   = OP_SIZE'('hE);

  logic [2:0]           state;
  logic [PC_SIZE-1:0]   pc;
  logic [WORD_SIZE-1:0] ir;
  logic [OP_SIZE-1:0]   ir_op;
  logic [OP_SIZE-1:0]   ir_rd;
  logic [OP_SIZE-1:0]   ir_rs;
  logic [OP_SIZE-1:0]   ir_rt;

  assign ir_op = ir[WORD_SIZE-1 -: OP_SIZE];
  assign ir_rd = ir[WORD_SIZE-1-OP_SIZE -: OP_SIZE];
  assign ir_rs = ir[WORD_SIZE-1-2*OP_SIZE -: OP_SIZE];
  assign ir_rt = ir[WORD_SIZE-1-3*OP_SIZE -: OP_SIZE];

  // Gated by rst so the request never shows while reset is held.
  assign imem_req    = (state == S_FETCH) && !rst;
  assign imem_addr   = pc;
  assign issue_valid = (state == S_ISSUE);
  assign halted      = (state == S_HALT);
  assign sel         = issue_valid ? ir_op : '0;

  always_ff @(posedge tclk) begin
    if (rst) begin
      state      <= S_FETCH;
      pc         <= '0;
      ir         <= '0;
      rf_raddr_a <= '0;
      rf_raddr_b <= '0;
      data1_out  <= '0;
      data2_out  <= '0;
      data3_out  <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ack) begin
            ir <= imem_data;
            pc <= pc + PC_SIZE'(1);
            // Read addresses go out at the start of DECODE so data lands in READ.
            rf_raddr_a <= imem_data[WORD_SIZE-1-2*OP_SIZE -: OP_SIZE];
            rf_raddr_b <= imem_data[WORD_SIZE-1-3*OP_SIZE -: OP_SIZE];
            state <= S_DECODE;
          end
        end
        S_DECODE: state <= S_READ;
        S_READ: begin
          if (ir_op == OP_NOP) begin
            state <= S_FETCH;
          end else if (ir_op == OP_HALT) begin
            state <= S_HALT;
          end else begin
            data1_out <= {{(WORD_SIZE-OP_SIZE){1'b0}}, ir_rd};
            if (ir_op == OP_LI) begin
              data2_out <= '0;
              data3_out <= {{(WORD_SIZE-2*OP_SIZE){1'b0}}, ir_rs, ir_rt};
            end else begin
              data2_out <= rf_rdata_a;
              data3_out <= rf_rdata_b;
            end
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (issue_ready) state <= S_FETCH;
        end
        S_HALT: state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule
